// File: rtl/clint_axi_slave.sv
// ---------------------------------------------------------------------------
// clint_axi_slave
//
// Purpose: AXI4 responder for the CLINT window of the CVA6 wrapper SoC. It
// holds a per-hart msip bit, a per-hart 64-bit mtimecmp and a shared 64-bit
// mtime counter advanced by rising edges of rtc_i. It drives the machine
// timer interrupt (mtime >= mtimecmp) and the machine software interrupt
// (msip) of every hart.
//
// Register map (offset = addr[19:0], decoded per 8-byte beat):
//   0x0000 + 4h  msip[h]     bit 0 only, lane 0 or lane 4 by addr[2]
//   0x4000 + 8h  mtimecmp[h] 64 bits
//   0xBFF8       mtime       64 bits
//   other        read 0 / write dropped, response DECERR
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   rtc_i                real-time tick; every rising edge adds 1 to mtime
//   aw_* / w_* / b_*     AXI4 write address, data and response channels
//   ar_* / r_*           AXI4 read address and data channels
//   timer_irq_o[h]       registered mtime >= mtimecmp[h]
//   ipi_o[h]             msip[h]
//
// Handshake rule on every channel: a transfer takes place on a rising clk
// edge where valid and ready are both high; a source keeps valid and its
// payload stable until that edge.
//
// Build option: define CLINT_RTC_SYNC_EN to pass rtc_i through a two-flop
// synchronizer ahead of the edge detector (rtc_i asynchronous to clk_i).
// Without it rtc_i is taken as synchronous and edge-detected directly.
// ---------------------------------------------------------------------------
module clint_axi_slave #(
   parameter int unsigned NrHarts      = 1,
   parameter int unsigned AxiIdWidth   = 3,
   parameter int unsigned AxiAddrWidth = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    rtc_i,
   input  logic                    aw_valid_i,
   output logic                    aw_ready_o,
   input  logic [AxiIdWidth-1:0]   aw_id_i,
   input  logic [AxiAddrWidth-1:0] aw_addr_i,
   input  logic [7:0]              aw_len_i,
   input  logic                    w_valid_i,
   output logic                    w_ready_o,
   input  logic [63:0]             w_data_i,
   input  logic [7:0]              w_strb_i,
   input  logic                    w_last_i,
   output logic                    b_valid_o,
   input  logic                    b_ready_i,
   output logic [AxiIdWidth-1:0]   b_id_o,
   output logic [1:0]              b_resp_o,
   input  logic                    ar_valid_i,
   output logic                    ar_ready_o,
   input  logic [AxiIdWidth-1:0]   ar_id_i,
   input  logic [AxiAddrWidth-1:0] ar_addr_i,
   input  logic [7:0]              ar_len_i,
   output logic                    r_valid_o,
   input  logic                    r_ready_i,
   output logic [AxiIdWidth-1:0]   r_id_o,
   output logic [63:0]             r_data_o,
   output logic [1:0]              r_resp_o,
   output logic                    r_last_o,
   output logic [NrHarts-1:0]      timer_irq_o,
   output logic [NrHarts-1:0]      ipi_o
);

   typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

   localparam logic [19:0] MtimeOff = 20'h0BFF8;
   localparam logic [19:0] CmpBase  = 20'h04000;
   localparam logic [1:0]  RespOkay = 2'b00;
   localparam logic [1:0]  RespDec  = 2'b11;

   // ------------------------------------------------------------------
   // RTC edge detection
   // ------------------------------------------------------------------
   logic rtc_tick;

`ifdef CLINT_RTC_SYNC_EN
   logic rtc_s1, rtc_s2, rtc_prev;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rtc_s1   <= 1'b0;
         rtc_s2   <= 1'b0;
         rtc_prev <= 1'b0;
      end else begin
         rtc_s1   <= rtc_i;
         rtc_s2   <= rtc_s1;
         rtc_prev <= rtc_s2;
      end
   end

   assign rtc_tick = rtc_s2 & ~rtc_prev;
`else
   logic rtc_prev;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rtc_prev <= 1'b0;
      else       rtc_prev <= rtc_i;
   end

   assign rtc_tick = rtc_i & ~rtc_prev;
`endif

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                  state;
   logic [19:0]             addr_q;
   logic [7:0]              len_q;
   logic [7:0]              beat_q;
   logic [AxiIdWidth-1:0]   id_q;
   logic                    decerr_q;
   logic                    last_write;   // last grant went to the write side
   logic [63:0]             mtime;
   logic [63:0]             mtimecmp [NrHarts];
   logic [NrHarts-1:0]      msip;

   // Arbitration: on a tie the channel not served last wins.
   assign aw_ready_o = (state == IDLE) && aw_valid_i && (!ar_valid_i || !last_write);
   assign ar_ready_o = (state == IDLE) && ar_valid_i && (!aw_valid_i || last_write);
   assign w_ready_o  = (state == WDATA);

   logic aw_hs, ar_hs, w_hs;
   assign aw_hs = aw_valid_i && aw_ready_o;
   assign ar_hs = ar_valid_i && ar_ready_o;
   assign w_hs  = w_valid_i && w_ready_o;

   assign ipi_o = msip;

   // ------------------------------------------------------------------
   // Read decode: beat 0 comes from the AR address, later beats from the
   // address following the beat currently presented.
   // ------------------------------------------------------------------
   logic [19:0] rd_addr;
   logic [19:0] rd_off;
   logic [63:0] rd_data;
   logic        rd_err;

   assign rd_addr = (state == RDATA) ? addr_q + 20'd8 : ar_addr_i[19:0];
   assign rd_off  = {rd_addr[19:3], 3'b000};

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b1;
      if (rd_off == MtimeOff) begin
         rd_data = mtime;
         rd_err  = 1'b0;
      end
      for (int h = 0; h < NrHarts; h++) begin
         if (rd_off == CmpBase + 20'(8 * h)) begin
            rd_data = mtimecmp[h];
            rd_err  = 1'b0;
         end
         // Two msip words share one beat: even hart in lane 0, odd in lane 4.
         if (rd_addr[19:3] == 17'(h / 2)) begin
            rd_data[32 * (h % 2)] = msip[h];
            rd_err                = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Write decode for the current beat address
   // ------------------------------------------------------------------
   logic [19:0]        wr_off;
   logic               wr_mtime;
   logic [NrHarts-1:0] wr_cmp;
   logic [NrHarts-1:0] wr_msip;
   logic               wr_err;
   logic [63:0]        wmask;

   assign wr_off = {addr_q[19:3], 3'b000};

   always_comb begin
      wr_mtime = (wr_off == MtimeOff);
      wr_cmp   = '0;
      wr_msip  = '0;
      for (int h = 0; h < NrHarts; h++) begin
         wr_cmp[h]  = (wr_off == CmpBase + 20'(8 * h));
         wr_msip[h] = (addr_q[19:3] == 17'(h / 2));
      end
      wr_err = !(wr_mtime || (|wr_cmp) || (|wr_msip));
   end

   always_comb begin
      wmask = '0;
      for (int i = 0; i < 8; i++) wmask[8*i +: 8] = {8{w_strb_i[i]}};
   end

   // ------------------------------------------------------------------
   // CLINT registers and interrupts
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mtime       <= '0;
         msip        <= '0;
         timer_irq_o <= '0;
         for (int h = 0; h < NrHarts; h++) mtimecmp[h] <= '1;
      end else begin
         // A bus write to mtime beats a coincident tick.
         if (w_hs && wr_mtime)
            mtime <= (mtime & ~wmask) | (w_data_i & wmask);
         else if (rtc_tick)
            mtime <= mtime + 64'd1;
         for (int h = 0; h < NrHarts; h++) begin
            if (w_hs && wr_cmp[h])
               mtimecmp[h] <= (mtimecmp[h] & ~wmask) | (w_data_i & wmask);
            if (w_hs && wr_msip[h] && w_strb_i[4 * (h % 2)])
               msip[h] <= w_data_i[32 * (h % 2)];
            timer_irq_o[h] <= (mtime >= mtimecmp[h]);
         end
      end
   end

   // ------------------------------------------------------------------
   // Transaction FSM
   // ------------------------------------------------------------------
   logic beat_err;
   assign beat_err = decerr_q | wr_err;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         id_q       <= '0;
         decerr_q   <= 1'b0;
         last_write <= 1'b0;
         b_valid_o  <= 1'b0;
         b_id_o     <= '0;
         b_resp_o   <= RespOkay;
         r_valid_o  <= 1'b0;
         r_id_o     <= '0;
         r_data_o   <= '0;
         r_resp_o   <= RespOkay;
         r_last_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (aw_hs) begin
                  state      <= WDATA;
                  addr_q     <= aw_addr_i[19:0];
                  len_q      <= aw_len_i;
                  id_q       <= aw_id_i;
                  beat_q     <= '0;
                  decerr_q   <= 1'b0;
                  last_write <= 1'b1;
               end else if (ar_hs) begin
                  state      <= RDATA;
                  addr_q     <= ar_addr_i[19:0];
                  len_q      <= ar_len_i;
                  id_q       <= ar_id_i;
                  beat_q     <= '0;
                  last_write <= 1'b0;
                  r_valid_o  <= 1'b1;
                  r_id_o     <= ar_id_i;
                  r_data_o   <= rd_data;
                  r_resp_o   <= rd_err ? RespDec : RespOkay;
                  r_last_o   <= (ar_len_i == 8'd0);
               end
            end
            WDATA: begin
               if (w_hs) begin
                  addr_q   <= addr_q + 20'd8;
                  beat_q   <= beat_q + 8'd1;
                  decerr_q <= beat_err;
                  // A burst that overruns its length is cut at beat len.
                  if (w_last_i || beat_q == len_q) begin
                     state     <= WRESP;
                     b_valid_o <= 1'b1;
                     b_id_o    <= id_q;
                     b_resp_o  <= beat_err ? RespDec : RespOkay;
                  end
               end
            end
            WRESP: begin
               if (b_ready_i) begin
                  b_valid_o <= 1'b0;
                  state     <= IDLE;
               end
            end
            RDATA: begin
               if (r_ready_i) begin
                  if (r_last_o) begin
                     r_valid_o <= 1'b0;
                     r_last_o  <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     addr_q   <= addr_q + 20'd8;
                     beat_q   <= beat_q + 8'd1;
                     r_data_o <= rd_data;
                     r_resp_o <= rd_err ? RespDec : RespOkay;
                     r_last_o <= (beat_q + 8'd1 == len_q);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Address bits above the 1 MiB window and below the beat size are not decoded.
   logic unused_bits;
   assign unused_bits = ^{aw_addr_i[AxiAddrWidth-1:20], ar_addr_i[AxiAddrWidth-1:20],
                          addr_q[2:0], rd_addr[2:0]};

endmodule

// File: tb/tb_clint_axi_slave.sv
// ---------------------------------------------------------------------------
// tb_clint_axi_slave
//
// Bench for clint_axi_slave. Driver tasks issue AXI transactions and, at
// issue time, push the expected B / R responses computed by a register-map
// model into queues; a monitor pops and compares on every B and R transfer.
// Interrupt timing, arbitration order and reset behaviour are checked
// directly against the model.
// ---------------------------------------------------------------------------
module tb_clint_axi_slave;

   localparam int NH  = 1;
   localparam int IDW = 3;
   localparam int AW  = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            rtc = 1'b0;
   logic            aw_valid = 1'b0;
   logic            aw_ready;
   logic [IDW-1:0]  aw_id = '0;
   logic [AW-1:0]   aw_addr = '0;
   logic [7:0]      aw_len = '0;
   logic            w_valid = 1'b0;
   logic            w_ready;
   logic [63:0]     w_data = '0;
   logic [7:0]      w_strb = '0;
   logic            w_last = 1'b0;
   logic            b_valid;
   logic            b_ready = 1'b0;
   logic [IDW-1:0]  b_id;
   logic [1:0]      b_resp;
   logic            ar_valid = 1'b0;
   logic            ar_ready;
   logic [IDW-1:0]  ar_id = '0;
   logic [AW-1:0]   ar_addr = '0;
   logic [7:0]      ar_len = '0;
   logic            r_valid;
   logic            r_ready = 1'b0;
   logic [IDW-1:0]  r_id;
   logic [63:0]     r_data;
   logic [1:0]      r_resp;
   logic            r_last;
   logic [NH-1:0]   timer_irq;
   logic [NH-1:0]   ipi;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   clint_axi_slave #(.NrHarts(NH), .AxiIdWidth(IDW), .AxiAddrWidth(AW)) dut (
      .clk_i(clk), .rst_i(rst), .rtc_i(rtc),
      .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
      .aw_addr_i(aw_addr), .aw_len_i(aw_len),
      .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
      .w_strb_i(w_strb), .w_last_i(w_last),
      .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
      .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id),
      .ar_addr_i(ar_addr), .ar_len_i(ar_len),
      .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
      .r_resp_o(r_resp), .r_last_o(r_last),
      .timer_irq_o(timer_irq), .ipi_o(ipi)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;

   logic [IDW+1:0]  exp_b_q[$];   // {id, resp}
   logic [IDW+66:0] exp_r_q[$];   // {id, resp, last, data}
   int              grant_q[$];   // 1 = write granted, 0 = read granted

   // Register-map reference model
   logic [63:0] mtime_m;
   logic [63:0] cmp_m [NH];
   logic        msip_m [NH];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   function automatic void model_reset();
      mtime_m = '0;
      for (int h = 0; h < NH; h++) begin
         cmp_m[h]  = '1;
         msip_m[h] = 1'b0;
      end
   endfunction

   // One beat against the register map; returns the response and the data
   // a read of that beat would see, and applies the write when is_wr is set.
   function automatic void model_access(input logic [19:0] off, input bit is_wr,
                                        input logic [63:0] wdata, input logic [7:0] strb,
                                        output logic [1:0] resp, output logic [63:0] rdata);
      int base;
      base  = int'(off) & ~7;
      resp  = 2'b11;
      rdata = '0;
      if (base == 'hBFF8) begin
         resp  = 2'b00;
         rdata = mtime_m;
         if (is_wr)
            for (int b = 0; b < 8; b++) if (strb[b]) mtime_m[8*b +: 8] = wdata[8*b +: 8];
      end else if (base >= 'h4000 && base < 'h4000 + 8 * NH) begin
         int k;
         k     = (base - 'h4000) / 8;
         resp  = 2'b00;
         rdata = cmp_m[k];
         if (is_wr)
            for (int b = 0; b < 8; b++) if (strb[b]) cmp_m[k][8*b +: 8] = wdata[8*b +: 8];
      end else if (base < 'h4000 && base / 4 < NH) begin
         resp = 2'b00;
         for (int h = base / 4; h < NH && h <= base / 4 + 1; h++) begin
            int lane;
            lane = 4 * h - base;
            rdata[8 * lane] = msip_m[h];
            if (is_wr && strb[lane]) msip_m[h] = wdata[8 * lane];
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic axi_write(input logic [19:0] off, input logic [63:0] data,
                            input logic [7:0] strb, input logic [IDW-1:0] id,
                            input int len, input bit tick_last);
      logic [1:0]  r1;
      logic [63:0] dummy;
      bit          err;
      bit          hs;
      int          n;
      err = 1'b0;
      for (int i = 0; i <= len; i++) begin
         model_access(off + 20'(8 * i), 1'b1, data + 64'(i), strb, r1, dummy);
         if (r1 != 2'b00) err = 1'b1;
      end
      exp_b_q.push_back({id, err ? 2'b11 : 2'b00});

      @(posedge clk); #1;
      aw_valid = 1'b1;
      aw_addr  = 64'h0200_0000 | 64'(off);
      aw_id    = id;
      aw_len   = 8'(len);
      n = 0;
      do begin
         @(negedge clk); hs = aw_ready; n++;
         @(posedge clk); #1;
      end while (!hs && n < 200);
      if (!hs) timeout_fail("aw_handshake");
      aw_valid = 1'b0;

      for (int i = 0; i <= len; i++) begin
         w_valid = 1'b1;
         w_data  = data + 64'(i);
         w_strb  = strb;
         w_last  = (i == len);
         if (tick_last && i == len) rtc = 1'b1;
         n = 0;
         do begin
            @(negedge clk); hs = w_ready; n++;
            @(posedge clk); #1;
         end while (!hs && n < 200);
         if (!hs) timeout_fail("w_handshake");
         w_valid = 1'b0;
         w_last  = 1'b0;
         if (tick_last) rtc = 1'b0;
      end

      b_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("b_latency", b_valid, 1'b1);
      hs = b_valid && b_ready;
      n  = 0;
      while (!hs && n < 200) begin
         @(posedge clk); #1;
         b_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         hs = b_valid && b_ready;
         n++;
      end
      if (!hs) timeout_fail("b_handshake");
      @(posedge clk); #1;
      b_ready = 1'b0;
   endtask

   task automatic axi_read(input logic [19:0] off, input logic [IDW-1:0] id, input int len);
      logic [1:0]  resp;
      logic [63:0] d;
      bit          hs;
      int          n;
      int          cnt;
      for (int i = 0; i <= len; i++) begin
         model_access(off + 20'(8 * i), 1'b0, 64'd0, 8'd0, resp, d);
         exp_r_q.push_back({id, resp, (i == len) ? 1'b1 : 1'b0, d});
      end

      @(posedge clk); #1;
      ar_valid = 1'b1;
      ar_addr  = 64'h0200_0000 | 64'(off);
      ar_id    = id;
      ar_len   = 8'(len);
      n = 0;
      do begin
         @(negedge clk); hs = ar_ready; n++;
         @(posedge clk); #1;
      end while (!hs && n < 200);
      if (!hs) timeout_fail("ar_handshake");
      ar_valid = 1'b0;

      r_ready = 1'($urandom_range(0, 1));
      cnt = 0;
      @(negedge clk);
      check("r_first_latency", r_valid, 1'b1);
      if (r_valid && r_ready) cnt++;
      n = 0;
      while (cnt <= len && n < 300) begin
         @(posedge clk); #1;
         r_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (r_valid && r_ready) cnt++;
         n++;
      end
      if (cnt <= len) timeout_fail("r_beats");
      @(posedge clk); #1;
      r_ready = 1'b0;
   endtask

   // One rtc rising edge; the timer interrupt must keep its old value one
   // cycle after the mtime update and follow the new mtime one cycle later.
   task automatic tick();
      logic exp_old;
      exp_old = (mtime_m >= cmp_m[0]);
      @(posedge clk); #1;
      rtc = 1'b1;
      mtime_m = mtime_m + 64'd1;
      @(posedge clk); #1;
      rtc = 1'b0;
      check("irq_hold", timer_irq[0], exp_old);
      @(posedge clk); #1;
      check("irq_follow", timer_irq[0], (mtime_m >= cmp_m[0]) ? 1'b1 : 1'b0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (b_valid && b_ready) begin
            if (exp_b_q.size() == 0) check("b_unexpected", 1'b1, 1'b0);
            else check("b_response", {b_id, b_resp}, exp_b_q.pop_front());
         end
         if (r_valid && r_ready) begin
            if (exp_r_q.size() == 0) check("r_unexpected", 1'b1, 1'b0);
            else check("r_beat", {r_id, r_resp, r_last, r_data}, exp_r_q.pop_front());
         end
         if (aw_valid && aw_ready) grant_q.push_back(1);
         if (ar_valid && ar_ready) grant_q.push_back(0);
      end
   end

   task automatic check_grants(input string name, input int first, input int second);
      check({name, "_count"}, 32'(grant_q.size()), 32'd2);
      if (grant_q.size() == 2) begin
         check({name, "_first"}, 32'(grant_q[0]), 32'(first));
         check({name, "_second"}, 32'(grant_q[1]), 32'(second));
      end
   endtask

   // ---------------- stimulus ----------------
   logic [19:0] offs [9] = '{20'h00000, 20'h00004, 20'h00008, 20'h04000, 20'h04008,
                             20'h0BFF0, 20'h0BFF8, 20'h01000, 20'h0C000};

   initial begin
      bit hs;
      int n;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_b_valid", b_valid, 1'b0);
      check("rst_r_valid", r_valid, 1'b0);
      check("rst_timer_irq", timer_irq, '0);
      check("rst_ipi", ipi, '0);
      check("rst_r_data", r_data, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_aw_ready", aw_ready, 1'b0);
      check("idle_ar_ready", ar_ready, 1'b0);
      check("idle_w_ready", w_ready, 1'b0);
      check("idle_outputs", {r_last, r_resp, r_id, b_resp, b_id}, '0);

      // Tie after reset: write first, then read; ipi follows msip
      grant_q.delete();
      fork
         axi_write(20'h00000, 64'h1, 8'h0F, 3'd1, 0, 1'b0);
         axi_read(20'h0BFF8, 3'd2, 0);
      join
      check_grants("arb_reset", 1, 0);
      check("ipi_set", ipi[0], 1'b1);

      // Last grant was a read: tie goes to the write
      grant_q.delete();
      fork
         axi_write(20'h00000, 64'h0, 8'h0F, 3'd3, 0, 1'b0);
         axi_read(20'h04000, 3'd4, 0);
      join
      check_grants("arb_after_read", 1, 0);
      check("ipi_clear", ipi[0], 1'b0);

      // Last grant was a write: tie goes to the read
      axi_write(20'h04008, 64'h1234, 8'hFF, 3'd0, 0, 1'b0);
      grant_q.delete();
      fork
         axi_write(20'h00004, 64'h1_0000_0000, 8'hF0, 3'd5, 0, 1'b0);
         axi_read(20'h04000, 3'd6, 0);
      join
      check_grants("arb_after_write", 0, 1);

      // Timer compare
      axi_write(20'h0BFF8, 64'h0, 8'hFF, 3'd1, 0, 1'b0);
      axi_write(20'h04000, 64'd5, 8'hFF, 3'd2, 0, 1'b0);
      @(negedge clk);
      check("irq_before", timer_irq[0], 1'b0);
      repeat (5) tick();
      axi_read(20'h0BFF8, 3'd3, 0);
      axi_write(20'h04000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'd4, 0, 1'b0);
      @(negedge clk);
      check("irq_cleared", timer_irq[0], 1'b0);

      // Burst across a hole and into mtime
      axi_read(20'h0BFF0, 3'd5, 1);

      // Bus write to mtime wins against a coincident tick
      axi_write(20'h0BFF8, 64'h1_0000_0007, 8'hFF, 3'd6, 0, 1'b0);
      axi_write(20'h0BFF8, 64'h10, 8'h0F, 3'd7, 0, 1'b1);
      axi_read(20'h0BFF8, 3'd1, 0);

      // Wrap from all ones
      axi_write(20'h0BFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'd2, 0, 1'b0);
      tick();
      axi_read(20'h0BFF8, 3'd3, 0);

      // Random traffic
      for (int t = 0; t < 40; t++) begin
         logic [19:0]    off;
         logic [IDW-1:0] id;
         int             len;
         off = offs[$urandom_range(0, 8)];
         id  = IDW'($urandom_range(0, 7));
         len = $urandom_range(0, 2);
         if ($urandom_range(0, 1) == 1)
            axi_write(off, {$urandom, $urandom}, 8'($urandom_range(0, 255)), id, len, 1'b0);
         else
            axi_read(off, id, len);
      end

      // Reset while a read beat is held
      @(posedge clk); #1;
      ar_valid = 1'b1;
      ar_addr  = 64'h0200_BFF8;
      ar_id    = 3'd6;
      ar_len   = 8'd0;
      r_ready  = 1'b0;
      n = 0;
      do begin
         @(negedge clk); hs = ar_ready; n++;
         @(posedge clk); #1;
      end while (!hs && n < 200);
      if (!hs) timeout_fail("rst_ar_handshake");
      ar_valid = 1'b0;
      @(posedge clk); #1;
      check("r_held", r_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_drops_r_valid", r_valid, 1'b0);
      check("rst_b_valid_mid", b_valid, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_irq_after", timer_irq[0], 1'b0);
      check("rst_ipi_after", ipi[0], 1'b0);
      axi_read(20'h0BFF8, 3'd7, 0);
      axi_read(20'h04000, 3'd1, 0);

      repeat (2) @(posedge clk);
      check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
      check("r_queue_drained", 32'(exp_r_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/clint_axi_slave.md
Name: clint_axi_slave

Overview:
- AXI4 responder for the CLINT window (base 0x0200_0000, length 0xC0000) of the CVA6 wrapper SoC bus. The CVA6 core is the initiator; the crossbar routes slave index CLINT to this block.
- Implements per-hart msip, per-hart mtimecmp and a shared mtime counter advanced by an RTC tick.
- Drives machine timer and software interrupts back to the harts.

Parameters:
- NrHarts, 1, number of harts served (1..16).
- AxiIdWidth, 3, AXI ID width on the slave side (master ID bits plus crossbar bits).
- AxiAddrWidth, 64, AXI address width; only bits [19:0] are decoded.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- rtc_i  in  1  real-time clock tick source; each rising edge advances mtime by 1
- aw_valid_i/aw_ready_o  in/out  1/1  write address handshake
- aw_id_i  in  AxiIdWidth  write transaction ID
- aw_addr_i  in  AxiAddrWidth  write start address
- aw_len_i  in  8  burst length minus 1
- w_valid_i/w_ready_o  in/out  1/1  write data handshake
- w_data_i  in  64  write data
- w_strb_i  in  8  byte strobes
- w_last_i  in  1  last write beat
- b_valid_o/b_ready_i  out/in  1/1  write response handshake
- b_id_o  out  AxiIdWidth  echoed AW ID
- b_resp_o  out  2  OKAY=00, DECERR=11
- ar_valid_i/ar_ready_o  in/out  1/1  read address handshake
- ar_id_i  in  AxiIdWidth  read transaction ID
- ar_addr_i  in  AxiAddrWidth  read start address
- ar_len_i  in  8  burst length minus 1
- r_valid_o/r_ready_i  out/in  1/1  read data handshake
- r_id_o  out  AxiIdWidth  echoed AR ID
- r_data_o  out  64  read data
- r_resp_o  out  2  per-beat response
- r_last_o  out  1  last read beat
- timer_irq_o  out  NrHarts  machine timer interrupt per hart
- ipi_o  out  NrHarts  machine software interrupt per hart

Behaviour:
- Map, offset = addr[19:0] with 8-byte beat alignment:
  - msip[h] at 0x0000 + 4h; bit 0 only; other bits read 0.
  - mtimecmp[h] at 0x4000 + 8h; 64 bits.
  - mtime at 0xBFF8; 64 bits.
  - Any other offset: read data 0, resp DECERR, writes dropped.
- Byte strobes are honoured per byte. msip uses lane 0 or lane 4, selected by addr[2].
- FSM states: IDLE, WDATA, WRESP, RDATA. One transaction at a time.
- IDLE arbitration:
  - If both aw_valid_i and ar_valid_i are high, grant the channel not served last; the flag resets to favour write.
  - The ready for the granted channel is high combinationally in IDLE. Capture ID, address and len, then go to WDATA or RDATA.
- WDATA:
  - w_ready_o=1. Each beat is applied on its handshake cycle; address advances by 8 per beat (INCR; burst type and size ignored).
  - A DECERR on any beat is sticky for the burst.
  - On w_last_i handshake, go to WRESP. A beat count exceeding len also ends the burst.
- WRESP: b_valid_o=1 and held until b_ready_i, then IDLE. Latency from the w_last handshake to b_valid is 1 cycle.
- RDATA:
  - r_valid_o asserts the cycle after AR acceptance; the registered beat is held stable until r_ready_i.
  - Each r handshake loads the next beat on the following cycle. r_last_o=1 on beat len. After the last handshake, go to IDLE.
- mtime:
  - Increments by 1 once per detected rtc rising edge and wraps 2^64-1 -> 0.
  - A bus write to mtime in the same cycle as an increment wins; that increment is dropped.
- timer_irq_o[h] is registered (mtime >= mtimecmp[h], unsigned) and updates 1 cycle after either operand changes. ipi_o[h] = msip[h] (registered).
- Reset values:
  - mtime=0, mtimecmp=all ones, msip=0, FSM=IDLE.
  - All valid/ready outputs 0, b_resp/r_resp/r_data/r_last/IDs 0, timer_irq_o=0, ipi_o=0.
- Reset mid-transaction: rst_i immediately forces IDLE and deasserts b_valid_o/r_valid_o. The in-flight transaction is lost and the partial write beats already applied stay applied.

Optional Feature:
- CLINT_RTC_SYNC_EN defined: rtc_i passes through a 2-flop synchronizer before the edge detector. mtime increments 3 cycles after the rtc_i rising edge.
- Undefined: rtc_i is treated as synchronous to clk_i and edge-detected directly. mtime increments 1 cycle after the edge.

Test Plan:
- Write 0x1 strb 0x0F to 0x0200_0000 -> b_resp=00 one cycle after w_last; ipi_o[0]=1. Write 0 -> ipi_o[0]=0.
- Write mtimecmp[0]=5, apply 5 rtc edges -> timer_irq_o[0] rises exactly when mtime reads 5; write mtimecmp=0xFFFF_FFFF_FFFF_FFFF -> irq clears next cycle.
- Read burst len=1 at 0x0200_BFF0 -> beat0 DECERR data 0, beat1 OKAY mtime value, r_last only on beat1, ID echoed.
- Simultaneous aw_valid and ar_valid after reset -> write granted first, read granted next; back-to-back repeat -> grants alternate.
- Write mtime lower strb 0x0F with 0x10 coincident with an rtc increment -> mtime reads 0x10, not 0x11; mtime=2^64-1 plus one tick -> 0.
- Assert rst_i while r_valid_o is held with r_ready_i=0 -> r_valid_o drops immediately; after release the block accepts a new AR in IDLE.
